// File: rtl/sweep_counter_ctrl_pkg.sv
// Shared constants and state encoding for the ping-pong sweep controller.
package sweep_counter_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH   = 8;
    localparam int unsigned DEFAULT_DWELL_W = 4;
    localparam int unsigned DEFAULT_SWEEP_W = 8;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam logic [2:0] STATE_IDLE     = 3'd0;
    localparam logic [2:0] STATE_UP       = 3'd1;
    localparam logic [2:0] STATE_DWELL_HI = 3'd2;
    localparam logic [2:0] STATE_DOWN     = 3'd3;
    localparam logic [2:0] STATE_DWELL_LO = 3'd4;
    localparam logic [2:0] STATE_DONE     = 3'd5;

    typedef enum logic [2:0] {
        StIdle    = STATE_IDLE,
        StUp      = STATE_UP,
        StDwellHi = STATE_DWELL_HI,
        StDown    = STATE_DOWN,
        StDwellLo = STATE_DWELL_LO,
        StDone    = STATE_DONE
    } state_t;

endpackage

// File: rtl/updown_counter_core.sv
// Loadable up/down counter datapath; load takes priority over count enable.
module updown_counter_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_down,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= up_down ? count + 1'b1 : count - 1'b1;
        end
    end

endmodule

// File: rtl/sweep_counter_ctrl.sv
// Sequencer driving the up/down counter as a lo->hi->lo sweep, repeated n_sweeps
// times with optional dwell at each endpoint.
module sweep_counter_ctrl
    import sweep_counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned DWELL_W = DEFAULT_DWELL_W,
    parameter int unsigned SWEEP_W = DEFAULT_SWEEP_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [SWEEP_W-1:0] n_sweeps,
    output logic [WIDTH-1:0]   count,
    output logic               dir_up,
    output logic               busy,
    output logic               at_edge,
    output logic               done,
    output logic               err,
    output logic [SWEEP_W-1:0] sweeps_done
);

    state_t             state_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   hi_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_cnt_q;
    logic [SWEEP_W-1:0] n_q;
    logic [SWEEP_W-1:0] sweeps_q;
    logic               dir_up_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic               idle_like;
    logic               start_ok;
    logic               start_take;
    logic               cnt_en;
    logic [WIDTH-1:0]   count_inc;
    logic [WIDTH-1:0]   count_dec;
    logic [SWEEP_W-1:0] sweeps_inc;

    assign idle_like  = (state_q == StIdle) || (state_q == StDone);
    assign start_ok   = (lo < hi) && (n_sweeps != '0);
    // Abort always wins over start, even when idle.
    assign start_take = idle_like && start && !abort;
    assign cnt_en     = ((state_q == StUp) || (state_q == StDown)) && !abort;
    assign count_inc  = count + 1'b1;
    assign count_dec  = count - 1'b1;
    assign sweeps_inc = sweeps_q + 1'b1;

    updown_counter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (cnt_en),
        .load    (start_take && start_ok),
        .load_val(lo),
        .up_down (dir_up_q),
        .count   (count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            lo_q        <= '0;
            hi_q        <= '0;
            dwell_q     <= '0;
            dwell_cnt_q <= '0;
            n_q         <= '0;
            sweeps_q    <= '0;
            dir_up_q    <= DIR_UP;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (abort && busy_q) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle, StDone: begin
                        if (start_take) begin
                            if (start_ok) begin
                                lo_q     <= lo;
                                hi_q     <= hi;
                                dwell_q  <= dwell;
                                n_q      <= n_sweeps;
                                sweeps_q <= '0;
                                dir_up_q <= DIR_UP;
                                busy_q   <= 1'b1;
                                state_q  <= StUp;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    StUp: begin
                        if (count_inc == hi_q) begin
                            if (dwell_q != '0) begin
                                dwell_cnt_q <= dwell_q;
                                state_q     <= StDwellHi;
                            end else begin
                                dir_up_q <= DIR_DOWN;
                                state_q  <= StDown;
                            end
                        end
                    end
                    StDwellHi: begin
                        if (dwell_cnt_q == DWELL_W'(1)) begin
                            dir_up_q <= DIR_DOWN;
                            state_q  <= StDown;
                        end else begin
                            dwell_cnt_q <= dwell_cnt_q - 1'b1;
                        end
                    end
                    StDown: begin
                        if (count_dec == lo_q) begin
                            sweeps_q <= sweeps_inc;
                            if (sweeps_inc == n_q) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= StDone;
                            end else begin
                                dir_up_q <= DIR_UP;
                                if (dwell_q != '0) begin
                                    dwell_cnt_q <= dwell_q;
                                    state_q     <= StDwellLo;
                                end else begin
                                    state_q <= StUp;
                                end
                            end
                        end
                    end
                    StDwellLo: begin
                        if (dwell_cnt_q == DWELL_W'(1)) begin
                            state_q <= StUp;
                        end else begin
                            dwell_cnt_q <= dwell_cnt_q - 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign dir_up      = dir_up_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign sweeps_done = sweeps_q;
    assign at_edge     = busy_q && ((count == hi_q) || (count == lo_q));

endmodule

// File: tb/tb_sweep_counter_ctrl.sv
// Directed bench for sweep_counter_ctrl with hand-computed expected sequences.
module tb_sweep_counter_ctrl;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [3:0] dwell;
    logic [7:0] n_sweeps;
    logic [7:0] count;
    logic       dir_up;
    logic       busy;
    logic       at_edge;
    logic       done;
    logic       err;
    logic [7:0] sweeps_done;

    int n_assert = 0;
    int n_fail   = 0;

    sweep_counter_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .lo         (lo),
        .hi         (hi),
        .dwell      (dwell),
        .n_sweeps   (n_sweeps),
        .count      (count),
        .dir_up     (dir_up),
        .busy       (busy),
        .at_edge    (at_edge),
        .done       (done),
        .err        (err),
        .sweeps_done(sweeps_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [7:0] l, input logic [7:0] h, input logic [3:0] d,
                             input logic [7:0] n);
        lo = l; hi = h; dwell = d; n_sweeps = n;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin : stim
        logic [7:0] exp1 [7];
        logic [7:0] exp2 [11];
        logic       dir2 [11];
        logic [7:0] exp6 [6];
        logic       early_done;

        exp1 = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd4, 8'd3, 8'd2};
        exp2 = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd0};
        dir2 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp6 = '{8'd4, 8'd5, 8'd6, 8'd6, 8'd5, 8'd4};

        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        lo = '0; hi = '0; dwell = '0; n_sweeps = '0;
        #12;
        chk("rst_count", count, 0);
        chk("rst_dir_up", dir_up, 1);
        chk("rst_busy", busy, 0);
        chk("rst_at_edge", at_edge, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_sweeps", sweeps_done, 0);
        reset_n = 1'b1;
        step();

        // Basic single sweep, no dwell.
        start_run(8'd2, 8'd5, 4'd0, 8'd1);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            chk($sformatf("t1_count_%0d", i), count, exp1[i]);
            chk($sformatf("t1_done_%0d", i), done, (i == 6) ? 1 : 0);
            chk($sformatf("t1_busy_%0d", i), busy, (i == 6) ? 0 : 1);
        end
        chk("t1_sweeps", sweeps_done, 1);
        step();
        chk("t1_done_clr", done, 0);

        // Dwell at both ends, minimum span, two sweeps.
        start_run(8'd0, 8'd1, 4'd2, 8'd2);
        for (int i = 0; i < 11; i++) begin
            if (i > 0) step();
            chk($sformatf("t2_count_%0d", i), count, exp2[i]);
            if (i < 10) chk($sformatf("t2_dir_%0d", i), dir_up, dir2[i]);
            chk($sformatf("t2_done_%0d", i), done, (i == 10) ? 1 : 0);
            if (i == 5) chk("t2_sweeps_mid", sweeps_done, 1);
        end
        chk("t2_sweeps", sweeps_done, 2);
        chk("t2_busy", busy, 0);

        // Rejected starts from DONE.
        start_run(8'd7, 8'd7, 4'd0, 8'd3);
        chk("t3_err_eq", err, 1);
        chk("t3_busy_eq", busy, 0);
        chk("t3_count_eq", count, 0);
        step();
        chk("t3_err_clr", err, 0);
        start_run(8'd3, 8'd9, 4'd0, 8'd0);
        chk("t3_err_n0", err, 1);
        chk("t3_busy_n0", busy, 0);
        chk("t3_sweeps_n0", sweeps_done, 2);
        step();

        // Abort on the way down during the second sweep at count 15.
        start_run(8'd10, 8'd20, 4'd0, 8'd4);
        for (int i = 0; i < 35; i++) step();
        chk("t4_count_pre", count, 15);
        chk("t4_dir_pre", dir_up, 0);
        chk("t4_sweeps_pre", sweeps_done, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_count", count, 15);
        chk("t4_sweeps", sweeps_done, 1);
        chk("t4_done", done, 0);
        chk("t4_dir", dir_up, 0);
        step();
        chk("t4_count_hold", count, 15);
        chk("t4_done_hold", done, 0);

        // Start and abort together: abort wins, both mid-run and idle.
        start_run(8'd10, 8'd20, 4'd0, 8'd4);
        step(); step(); step();
        chk("t4b_count_pre", count, 13);
        lo = 8'd0; hi = 8'd5; start = 1'b1; abort = 1'b1;
        step();
        chk("t4b_busy", busy, 0);
        chk("t4b_count", count, 13);
        chk("t4b_err", err, 0);
        step();
        start = 1'b0; abort = 1'b0;
        chk("t4b_idle_busy", busy, 0);
        chk("t4b_idle_count", count, 13);

        // Mid-run start and config changes are ignored.
        start_run(8'd2, 8'd5, 4'd0, 8'd1);
        lo = 8'd50; hi = 8'd60; dwell = 4'd3; n_sweeps = 8'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t5_count1", count, 3);
        chk("t5_err", err, 0);
        chk("t5_busy", busy, 1);
        step(); step();
        chk("t5_count_hi", count, 5);
        chk("t5_at_edge", at_edge, 1);
        step(); step(); step();
        chk("t5_count_end", count, 2);
        chk("t5_done", done, 1);

        // Asynchronous reset while dwelling at hi.
        start_run(8'd0, 8'd3, 4'd5, 8'd1);
        step(); step(); step();
        chk("t6_count_hi", count, 3);
        chk("t6_at_edge", at_edge, 1);
        #3 reset_n = 1'b0;
        #1;
        chk("t6_rst_count", count, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_dir", dir_up, 1);
        chk("t6_rst_at_edge", at_edge, 0);
        chk("t6_rst_done", done, 0);
        #2 reset_n = 1'b1;
        step();
        chk("t6_idle_busy", busy, 0);
        start_run(8'd4, 8'd6, 4'd1, 8'd1);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            chk($sformatf("t6_count_%0d", i), count, exp6[i]);
        end
        chk("t6_done", done, 1);

        // Maximum sweep count.
        start_run(8'd0, 8'd1, 4'd0, 8'd255);
        early_done = 1'b0;
        for (int i = 0; i < 509; i++) begin
            step();
            if (done) early_done = 1'b1;
        end
        chk("t7_early_done", early_done, 0);
        chk("t7_busy_pre", busy, 1);
        chk("t7_sweeps_pre", sweeps_done, 254);
        chk("t7_count_pre", count, 1);
        step();
        chk("t7_done", done, 1);
        chk("t7_sweeps", sweeps_done, 255);
        chk("t7_busy", busy, 0);
        chk("t7_count", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sweep_counter_ctrl.md
Name: sweep_counter_ctrl

Overview:
- Sequencing controller that drives an 8-bit up/down counter datapath as a ping-pong sweep: lo -> hi -> lo, repeated N times.
- Optional dwell (hold) at each endpoint.
- Sits between a host/config interface (start/abort plus sweep bounds) and consumers of the count, such as a scan address or DAC code.
- Reports busy, endpoint, completion and error status.

Parameters:
- WIDTH, 8, counter/bound width
- DWELL_W, 4, width of endpoint dwell length
- SWEEP_W, 8, width of sweep count and completed-sweep counter

Ports:
- clk  in  1  clock, rising-edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; request a new run
- abort  in  1  one-cycle pulse; terminate current run
- lo  in  WIDTH  lower sweep bound, captured on accepted start
- hi  in  WIDTH  upper sweep bound, captured on accepted start
- dwell  in  DWELL_W  extra hold cycles at each endpoint, captured on start
- n_sweeps  in  SWEEP_W  number of full lo->hi->lo sweeps, captured on start
- count  out  WIDTH  counter value (registered)
- dir_up  out  1  1 = counting up, 0 = counting down
- busy  out  1  run in progress
- at_edge  out  1  high while count == captured hi or lo during a run
- done  out  1  one-cycle pulse when final sweep completes
- err  out  1  one-cycle pulse when start is rejected
- sweeps_done  out  SWEEP_W  completed sweeps in the current/last run

Behaviour:
- Interface: one clock (clk); reset_n is asynchronous, active-low.
- Reset values: state IDLE, count 0, dir_up 1, busy 0, at_edge 0, done 0, err 0, sweeps_done 0, captured config 0.
- States: IDLE, UP, DWELL_HI, DOWN, DWELL_LO, DONE.
- DONE behaves as IDLE for start acceptance. count holds lo in DONE.

Start acceptance:
- Accepted only in IDLE/DONE.
- Start with lo >= hi or n_sweeps == 0: err = 1 on the next cycle, state stays IDLE/DONE, outputs otherwise unchanged.
- Start in any other state is ignored (no err).
- Accepted start at edge T: at T+1, count = lo, dir_up = 1, busy = 1, sweeps_done = 0, state UP. Config is captured; later changes to lo/hi/dwell/n_sweeps are ignored until the next start.

UP state:
- count <= count + 1 each cycle.
- If count + 1 == hi: go to DWELL_HI if dwell != 0, else DOWN with dir_up = 0.

DWELL_HI state:
- count holds for exactly dwell cycles, then DOWN with dir_up = 0.

DOWN state:
- count <= count - 1.
- If count - 1 == lo, a sweep completes: sweeps_done increments in that same edge.
- If the new sweeps_done == n_sweeps: go to DONE, busy = 0, done = 1 for one cycle.
- Otherwise go to DWELL_LO (dwell != 0) or UP, with dir_up = 1.

DWELL_LO state:
- Holds for dwell cycles, then UP.

Timing and arithmetic:
- Sweep period is 2*(hi-lo) + 2*dwell cycles. The final low dwell is skipped.
- hi - lo == 1 is legal: count alternates lo, hi, lo.
- Bounds are always within [lo, hi], so the counter never wraps.
- sweeps_done never exceeds n_sweeps, including n_sweeps = 2^SWEEP_W - 1.

abort:
- From any busy state: next cycle goes to IDLE, busy 0, count and sweeps_done hold, dir_up holds, no done pulse.
- Abort has priority over start in the same cycle. Abort in IDLE/DONE is a no-op.

reset_n mid-run:
- Immediate return to reset values; no done pulse.

at_edge:
- Combinational from registered state: busy && (count == hi_q || count == lo_q).

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE..DONE)
  - default WIDTH/DWELL_W/SWEEP_W
  - DIR_UP/DIR_DOWN constants
- Sub-module updown_counter_core:
  - inputs: clk, reset_n, en, load, load_val, up_down; output count
  - priority: load > en; the controller only drives its controls
- Dwell counter and sweep counter stay inline in sweep_counter_ctrl.

Test Plan:
- lo=2, hi=5, dwell=0, n=1, start at T -> count 2,3,4,5,4,3,2 at T+1..T+7; done at T+7; busy low at T+7; sweeps_done=1.
- lo=0, hi=1, dwell=2, n=2 -> count 0,1,1,1,0,0,0,1,1,1,0; dir_up flips at each endpoint; done on the final 0; sweeps_done=2.
- lo=7, hi=7, n=3 -> err pulse next cycle, busy stays 0. Then lo=3, hi=9, n=0 -> err again.
- Run lo=10, hi=20, n=4; assert abort when count=15 on the way down in sweep 2 -> IDLE next cycle, count=15 held, sweeps_done=1, no done. Repeat with start+abort in the same cycle -> abort wins.
- Mid-run start with different lo/hi -> ignored, sweep unchanged. Changing lo/hi inputs mid-run has no effect.
- Assert reset_n low asynchronously (between clock edges) mid-DWELL_HI -> outputs go to reset values immediately. Restart afterwards runs correctly. n=255 with lo=0, hi=1 -> done only after 255 sweeps.
